bc_execute_unit: RTL and testbench
==================================

# bc_execute_unit

Branch-conditional execution unit that consumes the decoded B-form stream (decoded opcode 24) produced by the B-format decoder. It buffers decoded instructions in a 2-entry queue, evaluates BO/BI against the condition register and an internal CTR, updates CTR and LR, and emits a registered branch-resolution record (taken flag, target, next fetch address) to the fetch redirect logic. It is the consumer end of the decoder's B-form output interface.

## Interface
- addressWidth, 64, instruction address / CTR / LR width
- opcodeSize, 12, decoded opcode width
- instructionCounterWidth, 64, major ID width
- PidSize, 20, process ID width; TidSize, 16, thread ID width
- bodyWidth, 28, decoded body: [0:4] BO, [5:9] BI, [10:25] BD (14-bit field with 2'b00 appended), [26] AA, [27] LK
- bcOpcode, 24, decoded opcode accepted by this unit
- queueDepth, 2, input queue entries

- clock_i  in  1  clock; all state updates on rising edge
- resetn_i  in  1  asynchronous, active-low reset
- enable_i  in  1  decoder output valid
- opcode_i  in  opcodeSize  decoded opcode
- instructionAddress_i  in  addressWidth  CIA
- instMajId_i  in  instructionCounterWidth  major ID
- instPid_i / instTid_i  in  PidSize / TidSize  process / thread ID
- is64Bit_i  in  1  64-bit mode
- instructionBody_i  in  bodyWidth  decoded body
- ready_o  out  1  queue can accept this cycle
- crBits_i  in  32  condition register; bit 0 = CR bit 32 (MSB)
- stall_i  in  1  downstream not consuming output
- flush_i  in  1  discard queued and output entries
- sprWrite_i  in  1  mtspr write strobe
- sprSel_i  in  1  0 = CTR, 1 = LR
- sprData_i  in  addressWidth  write data
- idle_o  out  1  queue empty and output not valid
- branchValid_o  out  1  resolution record valid
- branchTaken_o  out  1  condition met
- branchTarget_o  out  addressWidth  computed target
- nextAddress_o  out  addressWidth  target if taken else CIA+4
- majId_o / pid_o / tid_o  out  as inputs  carried from accepted entry
- ctr_o, lr_o  out  addressWidth  current architected CTR / LR

## Operation
- Enqueue when enable_i && opcode_i == bcOpcode && ready_o && !flush_i; other opcodes ignored. ready_o = queue not full (combinational from count only).
- Execute: head entry pops when output register free (!branchValid_o || !stall_i); result registered into output on same edge.
- CTR_M = is64Bit ? CTR : zero-extended CTR[32:63] after decrement.
- If BO[2] == 0: CTR <= CTR - 1 (full 64-bit wrap, 0 -> all ones), decrement applied regardless of outcome.
- ctr_ok = BO[2] | ((CTR_M != 0) ^ BO[3]), evaluated on decremented value.
- cond_ok = BO[0] | (crBits_i[BI] == BO[1]).
- taken = ctr_ok & cond_ok.
- EXTS(BD) = 16-bit BD sign-extended to 64. Target = AA ? EXTS(BD) : CIA + EXTS(BD), modulo 2^64; if !is64Bit, target[0:31] forced 0.
- LK == 1: LR <= CIA + 4 (upper 32 zeroed in 32-bit mode) regardless of taken.
- sprWrite_i honoured only when idle_o is high; otherwise ignored (issuer must wait for idle_o).
- flush_i: queue count <= 0, branchValid_o <= 0; CTR/LR keep updates from already-executed entries; simultaneous enqueue and execute dropped.

## Timing
- Reset (async, resetn_i low): queue empty, branchValid_o, branchTaken_o = 0, branchTarget_o, nextAddress_o, majId_o, pid_o, tid_o = 0, CTR = 0, LR = 0; ready_o = 1, idle_o = 1. Reset mid-operation discards all entries.
- Latency: accepted at edge N, result valid after edge N+1 when output free. Back-to-back throughput 1/cycle.
- Output held stable while branchValid_o && stall_i; consumed on any edge with stall_i low.
- Full: 2 queued + 1 output held = 3 in flight; ready_o low until a pop.
- Simultaneous enqueue and pop on full queue: not permitted (ready_o already low); on non-full queue both occur, count unchanged.
- CTR seen by entry k includes decrement of entry k-1 (strict program order).

## Test plan
- CIA 0x1000, BO=10100, BD=0x0010, AA=0, LK=0 -> taken=1, target 0x1010, nextAddress 0x1010, CTR unchanged, valid after edge N+1.
- CTR=2 via sprWrite, two back-to-back BO=10000 (bdnz) at 0x2000/0x2004 -> first taken CTR=1, second not taken CTR=0, nextAddress 0x2008.
- BO=01100, BI=2, crBits_i=0x20000000, LK=1, CIA 0x3000, BD=0xFFF8 -> taken, target 0x2FF8, LR=0x3004; crBits_i=0 -> not taken, LR still 0x3004.
- is64Bit=0, AA=1, BD=0xFF00 -> target 0x00000000FFFFFF00; CTR=0x1_00000001, BO=10000 -> CTR_M=0 -> not taken.
- stall_i high, 4 valid inputs -> 3 accepted, ready_o low on 4th; release stall -> outputs in order, 1/cycle.
- flush_i with 2 queued and output valid -> branchValid_o 0, idle_o 1 next cycle; resetn_i low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bc_execute_unit.sv
// bc_execute_unit: conditional-branch (B-form) execution unit.
// Buffers decoded bc instructions in a small FIFO, resolves BO/BI against the
// condition register and the internal CTR, updates CTR/LR and emits a registered
// branch-resolution record to the fetch redirect logic.
//
// Ports:
//   clock_i, resetn_i                  clock, async active-low reset
//   enable_i, opcode_i, ready_o        decoder handshake (only bcOpcode accepted)
//   instructionAddress_i, instMajId_i,
//   instPid_i, instTid_i, is64Bit_i,
//   instructionBody_i                  decoded instruction fields
//   crBits_i                           condition register, bit 0 (MSB) = CR32
//   stall_i, flush_i                   downstream back-pressure / discard
//   sprWrite_i, sprSel_i, sprData_i    mtspr to CTR (sel 0) or LR (sel 1)
//   idle_o                             nothing queued, no valid output
//   branchValid_o, branchTaken_o,
//   branchTarget_o, nextAddress_o,
//   majId_o, pid_o, tid_o              resolution record
//   ctr_o, lr_o                        architected CTR / LR
module bc_execute_unit #(
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned opcodeSize              = 12,
    parameter int unsigned instructionCounterWidth = 64,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned bodyWidth               = 28,
    parameter int unsigned bcOpcode                = 24,
    parameter int unsigned queueDepth              = 2
) (
    input  logic                               clock_i,
    input  logic                               resetn_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [instructionCounterWidth-1:0] instMajId_i,
    input  logic [PidSize-1:0]                 instPid_i,
    input  logic [TidSize-1:0]                 instTid_i,
    input  logic                               is64Bit_i,
    input  logic [bodyWidth-1:0]               instructionBody_i,
    output logic                               ready_o,
    input  logic [31:0]                        crBits_i,
    input  logic                               stall_i,
    input  logic                               flush_i,
    input  logic                               sprWrite_i,
    input  logic                               sprSel_i,
    input  logic [addressWidth-1:0]            sprData_i,
    output logic                               idle_o,
    output logic                               branchValid_o,
    output logic                               branchTaken_o,
    output logic [addressWidth-1:0]            branchTarget_o,
    output logic [addressWidth-1:0]            nextAddress_o,
    output logic [instructionCounterWidth-1:0] majId_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [addressWidth-1:0]            ctr_o,
    output logic [addressWidth-1:0]            lr_o
);

    localparam int unsigned PtrW = (queueDepth > 1) ? $clog2(queueDepth) : 1;
    localparam int unsigned CntW = $clog2(queueDepth + 1);
    localparam int unsigned HiW  = addressWidth - 32;

    typedef struct packed {
        logic [addressWidth-1:0]            cia;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic                               is64;
        logic [bodyWidth-1:0]               body;
    } entry_t;

    entry_t                      mem_q [queueDepth];
    entry_t                      mem_d [queueDepth];
    logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic                        valid_q, valid_d, taken_q, taken_d;
    logic [addressWidth-1:0]     target_q, target_d, next_q, next_d;
    logic [addressWidth-1:0]     ctr_q, ctr_d, lr_q, lr_d;
    logic [instructionCounterWidth-1:0] maj_q, maj_d;
    logic [PidSize-1:0]          pid_q, pid_d;
    logic [TidSize-1:0]          tid_q, tid_d;

    entry_t                  head;
    logic [4:0]              bo, bi;
    logic [15:0]             bd;
    logic                    aa, lk;
    logic [addressWidth-1:0] ctr_new, ctr_m, exts_bd, tgt_raw, tgt, cia4, lr_link;
    logic                    ctr_ok, cond_ok, taken;
    logic                    do_enq, do_exec, out_free, spr_wr;

    assign ready_o = (cnt_q != CntW'(queueDepth));
    assign idle_o  = (cnt_q == '0) && !valid_q;

    // Field decode of the head entry. BO bits are numbered MSB-first, so
    // architected BO[k] is bo[4-k].
    always_comb begin
        head    = mem_q[rd_ptr_q];
        bo      = head.body[bodyWidth-1 -: 5];
        bi      = head.body[bodyWidth-6 -: 5];
        bd      = head.body[bodyWidth-11 -: 16];
        aa      = head.body[1];
        lk      = head.body[0];
        ctr_new = bo[2] ? ctr_q : (ctr_q - addressWidth'(1));
        ctr_m   = head.is64 ? ctr_new : {{HiW{1'b0}}, ctr_new[31:0]};
        ctr_ok  = bo[2] | ((ctr_m != '0) ^ bo[1]);
        cond_ok = bo[4] | (crBits_i[5'd31 - bi] == bo[3]);
        taken   = ctr_ok & cond_ok;
        exts_bd = {{(addressWidth-16){bd[15]}}, bd};
        tgt_raw = aa ? exts_bd : (head.cia + exts_bd);
        tgt     = head.is64 ? tgt_raw : {{HiW{1'b0}}, tgt_raw[31:0]};
        cia4    = head.cia + addressWidth'(4);
        lr_link = head.is64 ? cia4 : {{HiW{1'b0}}, cia4[31:0]};
    end

    assign out_free = !valid_q || !stall_i;
    assign do_exec  = (cnt_q != '0) && out_free && !flush_i;
    assign do_enq   = enable_i && (opcode_i == opcodeSize'(bcOpcode)) && ready_o && !flush_i;
    // Only legal when idle, so it can never race an executing entry.
    assign spr_wr   = sprWrite_i && idle_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        taken_d  = taken_q;
        target_d = target_q;
        next_d   = next_q;
        maj_d    = maj_q;
        pid_d    = pid_q;
        tid_d    = tid_q;
        ctr_d    = ctr_q;
        lr_d     = lr_q;

        if (do_enq) begin
            mem_d[wr_ptr_q] = '{cia: instructionAddress_i, maj_id: instMajId_i, pid: instPid_i,
                                tid: instTid_i, is64: is64Bit_i, body: instructionBody_i};
            wr_ptr_d = (wr_ptr_q == PtrW'(queueDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            cnt_d    = cnt_d + CntW'(1);
        end

        if (!stall_i) valid_d = 1'b0;

        if (do_exec) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(queueDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            cnt_d    = cnt_d - CntW'(1);
            valid_d  = 1'b1;
            taken_d  = taken;
            target_d = tgt;
            next_d   = taken ? tgt : cia4;
            maj_d    = head.maj_id;
            pid_d    = head.pid;
            tid_d    = head.tid;
            ctr_d    = ctr_new;
            if (lk) lr_d = lr_link;
        end

        if (spr_wr) begin
            if (sprSel_i) lr_d  = sprData_i;
            else          ctr_d = sprData_i;
        end

        if (flush_i) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < int'(queueDepth); i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            next_q   <= '0;
            maj_q    <= '0;
            pid_q    <= '0;
            tid_q    <= '0;
            ctr_q    <= '0;
            lr_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            next_q   <= next_d;
            maj_q    <= maj_d;
            pid_q    <= pid_d;
            tid_q    <= tid_d;
            ctr_q    <= ctr_d;
            lr_q     <= lr_d;
        end
    end

    assign branchValid_o  = valid_q;
    assign branchTaken_o  = taken_q;
    assign branchTarget_o = target_q;
    assign nextAddress_o  = next_q;
    assign majId_o        = maj_q;
    assign pid_o          = pid_q;
    assign tid_o          = tid_q;
    assign ctr_o          = ctr_q;
    assign lr_o           = lr_q;

endmodule

// File: tb/tb_bc_execute_unit.sv
module tb_bc_execute_unit;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        enable_i;
    logic [11:0] opcode_i;
    logic [63:0] instructionAddress_i;
    logic [63:0] instMajId_i;
    logic [19:0] instPid_i;
    logic [15:0] instTid_i;
    logic        is64Bit_i;
    logic [27:0] instructionBody_i;
    logic        ready_o;
    logic [31:0] crBits_i;
    logic        stall_i;
    logic        flush_i;
    logic        sprWrite_i;
    logic        sprSel_i;
    logic [63:0] sprData_i;
    logic        idle_o;
    logic        branchValid_o;
    logic        branchTaken_o;
    logic [63:0] branchTarget_o;
    logic [63:0] nextAddress_o;
    logic [63:0] majId_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [63:0] ctr_o;
    logic [63:0] lr_o;

    bc_execute_unit dut (
        .clock_i(clock_i), .resetn_i(resetn_i), .enable_i(enable_i), .opcode_i(opcode_i),
        .instructionAddress_i(instructionAddress_i), .instMajId_i(instMajId_i),
        .instPid_i(instPid_i), .instTid_i(instTid_i), .is64Bit_i(is64Bit_i),
        .instructionBody_i(instructionBody_i), .ready_o(ready_o), .crBits_i(crBits_i),
        .stall_i(stall_i), .flush_i(flush_i), .sprWrite_i(sprWrite_i), .sprSel_i(sprSel_i),
        .sprData_i(sprData_i), .idle_o(idle_o), .branchValid_o(branchValid_o),
        .branchTaken_o(branchTaken_o), .branchTarget_o(branchTarget_o),
        .nextAddress_o(nextAddress_o), .majId_o(majId_o), .pid_o(pid_o), .tid_o(tid_o),
        .ctr_o(ctr_o), .lr_o(lr_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic        taken;
        logic [63:0] tgt;
        logic [63:0] nxt;
        logic [63:0] maj;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [4:0] bo, input logic [4:0] bi,
                                       input logic [15:0] bd, input logic aa, input logic lk);
        return {bo, bi, bd, aa, lk};
    endfunction

    // Drive one bc instruction for one edge and record its expected result.
    task automatic send(input logic [63:0] cia, input logic [27:0] body, input logic is64,
                        input logic [63:0] maj, input logic e_taken, input logic [63:0] e_tgt,
                        input logic [63:0] e_nxt);
        enable_i             = 1'b1;
        opcode_i             = 12'd24;
        instructionAddress_i = cia;
        instMajId_i          = maj;
        instPid_i            = maj[19:0];
        instTid_i            = maj[15:0];
        is64Bit_i            = is64;
        instructionBody_i    = body;
        sb.push_back('{taken: e_taken, tgt: e_tgt, nxt: e_nxt, maj: maj});
        @(posedge clock_i); #1;
        enable_i = 1'b0;
    endtask

    task automatic spr_write(input logic sel, input logic [63:0] data);
        sprWrite_i = 1'b1;
        sprSel_i   = sel;
        sprData_i  = data;
        @(posedge clock_i); #1;
        sprWrite_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!idle_o && n < 50) begin
            @(posedge clock_i); #1;
            n++;
        end
        check(tag, idle_o, 1'b1);
    endtask

    // Scoreboard: an output is consumed at the next edge when valid and not stalled.
    always @(negedge clock_i) begin
        if (resetn_i && branchValid_o && !stall_i && !flush_i) begin
            check("sb_has_entry", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_taken", branchTaken_o, mon_e.taken);
                check("out_target", branchTarget_o, mon_e.tgt);
                check("out_next", nextAddress_o, mon_e.nxt);
                check("out_majid", majId_o, mon_e.maj);
                check("out_pid", pid_o, mon_e.maj[19:0]);
                check("out_tid", tid_o, mon_e.maj[15:0]);
            end
        end
    end

    initial begin
        resetn_i = 1'b0; enable_i = 1'b0; opcode_i = '0; instructionAddress_i = '0;
        instMajId_i = '0; instPid_i = '0; instTid_i = '0; is64Bit_i = 1'b1;
        instructionBody_i = '0; crBits_i = '0; stall_i = 1'b0; flush_i = 1'b0;
        sprWrite_i = 1'b0; sprSel_i = 1'b0; sprData_i = '0;

        // Reset state
        #12;
        check("rst_ready", ready_o, 1'b1);
        check("rst_idle", idle_o, 1'b1);
        check("rst_valid", branchValid_o, 1'b0);
        check("rst_ctr", ctr_o, 64'h0);
        check("rst_lr", lr_o, 64'h0);
        @(posedge clock_i); #1;
        resetn_i = 1'b1;

        // Foreign opcode is ignored
        enable_i = 1'b1; opcode_i = 12'd25;
        instructionBody_i = mk(5'b10100, 5'd0, 16'h0010, 1'b0, 1'b0);
        @(posedge clock_i); #1;
        enable_i = 1'b0;
        check("foreign_opcode_idle", idle_o, 1'b1);

        // Unconditional branch, latency
        send(64'h1000, mk(5'b10100, 5'd0, 16'h0010, 1'b0, 1'b0), 1'b1, 64'd1,
             1'b1, 64'h1010, 64'h1010);
        check("t1_lat_n", branchValid_o, 1'b0);
        @(posedge clock_i); #1;
        check("t1_lat_n1", branchValid_o, 1'b1);
        wait_idle("t1_idle");
        check("t1_ctr", ctr_o, 64'h0);

        // bdnz pair, CTR=2
        spr_write(1'b0, 64'd2);
        check("t2_ctr_wr", ctr_o, 64'd2);
        send(64'h2000, mk(5'b10000, 5'd0, 16'h0100, 1'b0, 1'b0), 1'b1, 64'd2,
             1'b1, 64'h2100, 64'h2100);
        send(64'h2004, mk(5'b10000, 5'd0, 16'h0100, 1'b0, 1'b0), 1'b1, 64'd3,
             1'b0, 64'h2104, 64'h2008);
        check("t2_ctr1", ctr_o, 64'd1);
        wait_idle("t2_idle");
        check("t2_ctr0", ctr_o, 64'd0);

        // CR-conditional with link
        crBits_i = 32'h2000_0000;
        send(64'h3000, mk(5'b01100, 5'd2, 16'hFFF8, 1'b0, 1'b1), 1'b1, 64'd4,
             1'b1, 64'h2FF8, 64'h2FF8);
        wait_idle("t3a_idle");
        check("t3a_lr", lr_o, 64'h3004);
        spr_write(1'b1, 64'h0);
        check("t3_lr_wr", lr_o, 64'h0);
        crBits_i = 32'h0;
        send(64'h3000, mk(5'b01100, 5'd2, 16'hFFF8, 1'b0, 1'b1), 1'b1, 64'd5,
             1'b0, 64'h2FF8, 64'h3004);
        wait_idle("t3b_idle");
        check("t3b_lr", lr_o, 64'h3004);

        // 32-bit mode: absolute target truncation, CTR_M uses low word
        send(64'h4000, mk(5'b10100, 5'd0, 16'hFF00, 1'b1, 1'b0), 1'b0, 64'd6,
             1'b1, 64'h0000_0000_FFFF_FF00, 64'h0000_0000_FFFF_FF00);
        wait_idle("t4a_idle");
        spr_write(1'b0, 64'h1_0000_0001);
        send(64'h5000, mk(5'b10000, 5'd0, 16'h0040, 1'b0, 1'b0), 1'b0, 64'd7,
             1'b0, 64'h5040, 64'h5004);
        wait_idle("t4b_idle");
        check("t4b_ctr", ctr_o, 64'h1_0000_0000);
        // 64-bit CTR wrap 0 -> all ones
        spr_write(1'b0, 64'h0);
        send(64'h5100, mk(5'b10000, 5'd0, 16'h0040, 1'b0, 1'b0), 1'b1, 64'd8,
             1'b1, 64'h5140, 64'h5140);
        wait_idle("t4c_idle");
        check("t4c_ctr_wrap", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);

        // Stall: 3 in flight, 4th refused, mtspr ignored while busy
        stall_i = 1'b1;
        send(64'h6000, mk(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0), 1'b1, 64'd10,
             1'b1, 64'h6008, 64'h6008);
        check("t5_ready1", ready_o, 1'b1);
        send(64'h6010, mk(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0), 1'b1, 64'd11,
             1'b1, 64'h6018, 64'h6018);
        check("t5_ready2", ready_o, 1'b1);
        send(64'h6020, mk(5'b10100, 5'd0, 16'h0008, 1'b0, 1'b0), 1'b1, 64'd12,
             1'b1, 64'h6028, 64'h6028);
        check("t5_ready_full", ready_o, 1'b0);
        check("t5_valid", branchValid_o, 1'b1);
        enable_i = 1'b1; opcode_i = 12'd24; instructionAddress_i = 64'h6030;
        instMajId_i = 64'd99;
        @(posedge clock_i); #1;
        enable_i = 1'b0;
        check("t5_hold_target", branchTarget_o, 64'h6008);
        spr_write(1'b0, 64'hDEAD);
        check("t5_spr_ignored", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);
        stall_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            check("t5_stream_valid", branchValid_o, 1'b1);
        end
        @(posedge clock_i); #1;
        check("t5_drained_idle", idle_o, 1'b1);

        // Flush with 2 queued + output held
        stall_i = 1'b1;
        send(64'h7000, mk(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b0), 1'b1, 64'd20,
             1'b1, 64'h7004, 64'h7004);
        send(64'h7010, mk(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b0), 1'b1, 64'd21,
             1'b1, 64'h7014, 64'h7014);
        send(64'h7020, mk(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b0), 1'b1, 64'd22,
             1'b1, 64'h7024, 64'h7024);
        check("t6_full", ready_o, 1'b0);
        flush_i = 1'b1;
        @(posedge clock_i); #1;
        flush_i = 1'b0;
        sb.delete();
        check("t6_valid", branchValid_o, 1'b0);
        check("t6_idle", idle_o, 1'b1);
        stall_i = 1'b0;
        send(64'h7100, mk(5'b10100, 5'd0, 16'h0004, 1'b0, 1'b0), 1'b1, 64'd23,
             1'b1, 64'h7104, 64'h7104);
        wait_idle("t6_after_idle");

        // Asynchronous reset mid-stream
        stall_i = 1'b1;
        send(64'h8000, mk(5'b10100, 5'd0, 16'h0020, 1'b0, 1'b1), 1'b1, 64'd30,
             1'b1, 64'h8020, 64'h8020);
        send(64'h8004, mk(5'b10100, 5'd0, 16'h0020, 1'b0, 1'b1), 1'b1, 64'd31,
             1'b1, 64'h8024, 64'h8024);
        check("t7_pre_valid", branchValid_o, 1'b1);
        #2;
        resetn_i = 1'b0;
        #1;
        check("t7_valid", branchValid_o, 1'b0);
        check("t7_taken", branchTaken_o, 1'b0);
        check("t7_target", branchTarget_o, 64'h0);
        check("t7_next", nextAddress_o, 64'h0);
        check("t7_majid", majId_o, 64'h0);
        check("t7_ctr", ctr_o, 64'h0);
        check("t7_lr", lr_o, 64'h0);
        check("t7_ready", ready_o, 1'b1);
        check("t7_idle", idle_o, 1'b1);
        sb.delete();
        stall_i = 1'b0;
        @(posedge clock_i); #1;
        resetn_i = 1'b1;
        @(posedge clock_i); #1;

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
